// File: rtl/alu_result_drain.sv
// ALU result drain: captures the 64-bit ALU result and opcode on start, then
// writes it onto the 32-bit datapath bus (LO/HI or Rz) under bus_grant.
module alu_result_drain #(
  parameter int DATA_W = 32
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  start,
  input  logic [4:0]            opcode,
  input  logic [2*DATA_W-1:0]   c,
  input  logic                  bus_grant,
  output logic [DATA_W-1:0]     bus_out,
  output logic                  bus_en,
  output logic                  lo_we,
  output logic                  hi_we,
  output logic                  rz_we,
  output logic                  busy,
  output logic                  done,
  output logic                  illegal,
  output logic                  zero_flag,
  output logic                  neg_flag
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_LO,
    S_WR_HI,
    S_WR_RZ,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    K_ILLEGAL,
    K_NOP,
    K_SINGLE,
    K_DOUBLE
  } op_kind_e;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_XOR  = 5'b01101;
  localparam logic [4:0] OP_NOR  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;

  function automatic op_kind_e classify(input logic [4:0] op);
    case (op)
      OP_MUL, OP_DIV: return K_DOUBLE;
      OP_NOP:         return K_NOP;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA,
      OP_SHL, OP_XOR, OP_NOR, OP_NEG, OP_NOT:
                      return K_SINGLE;
      default:        return K_ILLEGAL;
    endcase
  endfunction

  state_e              state_q, state_d;
  logic [2*DATA_W-1:0] z_q, z_d;
  logic [4:0]          op_q, op_d;
  logic                zero_q, zero_d;
  logic                neg_q, neg_d;
  op_kind_e            start_kind;

  assign start_kind = classify(opcode);

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= S_IDLE;
      z_q     <= '0;
      op_q    <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      op_q    <= op_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
    end
  end

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    z_d     = z_q;
    op_d    = op_q;
    zero_d  = zero_q;
    neg_d   = neg_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          z_d  = c;
          op_d = opcode;
          unique case (start_kind)
            K_DOUBLE: begin
              zero_d  = (c == '0);
              neg_d   = c[2*DATA_W-1];
              state_d = S_WR_LO;
            end
            K_SINGLE: begin
              zero_d  = (c[DATA_W-1:0] == '0);
              neg_d   = c[DATA_W-1];
              state_d = S_WR_RZ;
            end
            default: state_d = S_DONE;  // nop and unrecognised codes keep flags
          endcase
        end
      end
      S_WR_LO: if (bus_grant) state_d = S_WR_HI;
      S_WR_HI: if (bus_grant) state_d = S_DONE;
      S_WR_RZ: if (bus_grant) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus_out = '0;
    bus_en  = 1'b0;
    lo_we   = 1'b0;
    hi_we   = 1'b0;
    rz_we   = 1'b0;

    unique case (state_q)
      S_WR_LO: begin
        bus_en  = 1'b1;
        bus_out = z_q[DATA_W-1:0];
        lo_we   = bus_grant;
      end
      S_WR_HI: begin
        bus_en  = 1'b1;
        bus_out = z_q[2*DATA_W-1:DATA_W];
        hi_we   = bus_grant;
      end
      S_WR_RZ: begin
        bus_en  = 1'b1;
        bus_out = z_q[DATA_W-1:0];
        rz_we   = bus_grant;
      end
      default: ;
    endcase
  end

  // Status outputs decode registered state only; OP still holds the captured
  // code while in DONE, so the illegal pulse lines up with done.
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign illegal   = (state_q == S_DONE) && (classify(op_q) == K_ILLEGAL);
  assign zero_flag = zero_q;
  assign neg_flag  = neg_q;

endmodule

// File: tb/tb_alu_result_drain.sv
// Randomized self-checking bench for alu_result_drain against a transaction-
// level model: each op expands to the list of words it must write on the bus.
module tb_alu_result_drain;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic [4:0]  opcode;
  logic [63:0] c;
  logic        bus_grant;
  logic [31:0] bus_out;
  logic        bus_en, lo_we, hi_we, rz_we;
  logic        busy, done, illegal, zero_flag, neg_flag;

  int   errors = 0;
  int   checks = 0;
  logic exp_zero = 1'b0;
  logic exp_neg  = 1'b0;

  localparam int KIND_ILLEGAL = 0;
  localparam int KIND_NOP     = 1;
  localparam int KIND_SINGLE  = 2;
  localparam int KIND_DOUBLE  = 3;

  logic [4:0] legal_ops [16] = '{5'b00011, 5'b00100, 5'b10000, 5'b01111,
                                 5'b00101, 5'b00110, 5'b01101, 5'b01110,
                                 5'b10001, 5'b10010, 5'b01001, 5'b01011,
                                 5'b01010, 5'b00111, 5'b01000, 5'b11010};

  always #5 clock = ~clock;

  alu_result_drain #(.DATA_W(32)) dut (
    .clock     (clock),
    .clear     (clear),
    .start     (start),
    .opcode    (opcode),
    .c         (c),
    .bus_grant (bus_grant),
    .bus_out   (bus_out),
    .bus_en    (bus_en),
    .lo_we     (lo_we),
    .hi_we     (hi_we),
    .rz_we     (rz_we),
    .busy      (busy),
    .done      (done),
    .illegal   (illegal),
    .zero_flag (zero_flag),
    .neg_flag  (neg_flag)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int kind_of(input logic [4:0] op);
    if (op == 5'b10000 || op == 5'b01111) return KIND_DOUBLE;
    if (op == 5'b11010) return KIND_NOP;
    for (int i = 0; i < 16; i++) if (legal_ops[i] == op) return KIND_SINGLE;
    return KIND_ILLEGAL;
  endfunction

  // One cycle: drive inputs mid-low-phase, let combinational outputs settle.
  task automatic drive(input logic g, input logic s, input logic [4:0] op,
                       input logic [63:0] cv, input logic clr);
    @(negedge clock);
    clear     = clr;
    bus_grant = g;
    start     = s;
    opcode    = op;
    c         = cv;
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] bo, input logic en,
                            input logic lo, input logic hi, input logic rz,
                            input logic bsy, input logic dn, input logic ill);
    check({tag, ".bus_out"}, {32'h0, bus_out}, {32'h0, bo});
    check({tag, ".bus_en"},  {63'h0, bus_en},  {63'h0, en});
    check({tag, ".lo_we"},   {63'h0, lo_we},   {63'h0, lo});
    check({tag, ".hi_we"},   {63'h0, hi_we},   {63'h0, hi});
    check({tag, ".rz_we"},   {63'h0, rz_we},   {63'h0, rz});
    check({tag, ".busy"},    {63'h0, busy},    {63'h0, bsy});
    check({tag, ".done"},    {63'h0, done},    {63'h0, dn});
    check({tag, ".illegal"}, {63'h0, illegal}, {63'h0, ill});
  endtask

  task automatic check_flags(input string tag);
    check({tag, ".zero_flag"}, {63'h0, zero_flag}, {63'h0, exp_zero});
    check({tag, ".neg_flag"},  {63'h0, neg_flag},  {63'h0, exp_neg});
  endtask

  // fixed_stall < 0 picks random stalls per word; noise re-pulses start (add)
  // in every busy cycle, which must be ignored.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [63:0] cv,
                        input int fixed_stall, input bit noise);
    int          k;
    logic [31:0] words [$];
    int          sel [$];
    k = kind_of(op);
    drive(1'b1, 1'b1, op, cv, 1'b0);
    expect_out({tag, ".idle"}, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    if (k == KIND_DOUBLE) begin
      exp_zero = (cv == 64'h0);
      exp_neg  = cv[63];
      words    = '{cv[31:0], cv[63:32]};
      sel      = '{1, 2};
    end else if (k == KIND_SINGLE) begin
      exp_zero = (cv[31:0] == 32'h0);
      exp_neg  = cv[31];
      words    = '{cv[31:0]};
      sel      = '{3};
    end
    foreach (words[i]) begin
      int stalls;
      stalls = (fixed_stall >= 0) ? fixed_stall : $urandom_range(0, 3);
      for (int j = 0; j < stalls; j++) begin
        drive(1'b0, noise, 5'b00011, {$urandom, $urandom}, 1'b0);
        expect_out($sformatf("%s.stall%0d", tag, i), words[i], 1, 0, 0, 0, 1, 0, 0);
      end
      drive(1'b1, noise, 5'b00011, {$urandom, $urandom}, 1'b0);
      expect_out($sformatf("%s.word%0d", tag, i), words[i], 1,
                 sel[i] == 1, sel[i] == 2, sel[i] == 3, 1, 0, 0);
      check_flags($sformatf("%s.word%0d", tag, i));
    end
    drive(1'($urandom_range(0, 1)), noise, 5'b00011, {$urandom, $urandom}, 1'b0);
    expect_out({tag, ".done"}, 32'h0, 0, 0, 0, 0, 1, 1, k == KIND_ILLEGAL);
    check_flags({tag, ".done"});
    drive(1'($urandom_range(0, 1)), 1'b0, op, cv, 1'b0);
    expect_out({tag, ".after"}, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    check_flags({tag, ".after"});
  endtask

  initial begin
    clear     = 1'b1;
    start     = 1'b1;
    opcode    = 5'b10000;
    c         = 64'hFFFF_FFFF_8000_0000;
    bus_grant = 1'b1;

    // Reset held two cycles with start asserted: nothing captured.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 5'b10000, 64'hFFFF_FFFF_8000_0000, 1'b1);
      expect_out($sformatf("reset%0d", i), 32'h0, 0, 0, 0, 0, 0, 0, 0);
      check_flags($sformatf("reset%0d", i));
    end
    drive(1'b1, 1'b0, 5'b10000, 64'h0, 1'b0);
    expect_out("reset.release", 32'h0, 0, 0, 0, 0, 0, 0, 0);
    check_flags("reset.release");

    run_op("mul",  5'b10000, 64'hFFFF_FFFF_8000_0000, 0, 1'b0);
    run_op("nop",  5'b11010, 64'h0, 0, 1'b0);           // flags stay neg=1 zero=0
    run_op("add0", 5'b00011, 64'h0, 3, 1'b0);
    run_op("ill",  5'b11111, 64'hDEAD_BEEF_0000_0001, 0, 1'b0);
    run_op("div",  5'b01111, 64'h1_0000_0002, 0, 1'b1);

    // Abort: clear during WR_HI of a mul.
    drive(1'b1, 1'b1, 5'b10000, 64'h8765_4321_8000_0001, 1'b0);
    exp_zero = 1'b0;
    exp_neg  = 1'b1;
    drive(1'b1, 1'b0, 5'b00000, 64'h0, 1'b0);
    expect_out("abort.lo", 32'h8000_0001, 1, 1, 0, 0, 1, 0, 0);
    drive(1'b1, 1'b0, 5'b00000, 64'h0, 1'b1);
    expect_out("abort.hi", 32'h8765_4321, 1, 0, 1, 0, 1, 0, 0);
    exp_zero = 1'b0;
    exp_neg  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 5'b00000, 64'h0, 1'b0);
      expect_out($sformatf("abort.post%0d", i), 32'h0, 0, 0, 0, 0, 0, 0, 0);
      check_flags($sformatf("abort.post%0d", i));
    end

    // Randomized transactions.
    for (int n = 0; n < 150; n++) begin
      logic [4:0]  op;
      logic [63:0] cv;
      op = ($urandom_range(0, 9) < 7) ? legal_ops[$urandom_range(0, 15)] : 5'($urandom);
      cv = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) cv[31:0] = 32'h0;
      if ($urandom_range(0, 9) == 0) cv = 64'h0;
      run_op($sformatf("rnd%0d", n), op, cv, -1, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
